// File: rtl/mult_arb_pkg.sv
// Shared constants, operand record and tag-width helper for the multiplier-sharing arbiter.
package mult_arb_pkg;
  localparam int MUL_W   = 32;
  localparam int RES_W   = 64;
  localparam int MAX_REQ = 8;

  typedef struct packed {
    logic [MUL_W-1:0] src1;
    logic [MUL_W-1:0] src2;
    logic             src1_signed;
    logic             src2_signed;
  } mul_op_t;

  function automatic int tag_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: first asserted request at or after ptr (mod N) wins.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int TAG_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [TAG_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [TAG_W-1:0] idx,
  output logic             any
);
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[(int'(ptr) + k) % N]) begin
        any = 1'b1;
        idx = TAG_W'((int'(ptr) + k) % N);
      end
    end
    if (any) gnt = N'(1) << idx;
  end
endmodule

// File: rtl/mult_share_arb.sv
// Shares one two-stage pipelined 32x32 multiplier cell among NUM_REQ requesters.
// Optional saturating perf counters are built when MULT_ARB_PERF_EN is defined.
module mult_share_arb
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = tag_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*MUL_W-1:0] req_src1,
  input  logic [NUM_REQ*MUL_W-1:0] req_src2,
  input  logic [NUM_REQ-1:0]       req_src1_signed,
  input  logic [NUM_REQ-1:0]       req_src2_signed,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [RES_W-1:0]         rsp_result,
  output logic [MUL_W-1:0]         mul_src1,
  output logic [MUL_W-1:0]         mul_src2,
  output logic                     mul_src1_signed,
  output logic                     mul_src2_signed,
  output logic                     mul_m_en,
  output logic                     mul_a_en,
  output logic                     mul_clr,
  input  logic [RES_W-1:0]         mul_result,
  output logic [31:0]              perf_ops,
  output logic [31:0]              perf_stall
);
  mul_op_t [NUM_REQ-1:0] ops;
  mul_op_t               sel;
  logic [NUM_REQ-1:0]    gnt;
  logic [TAG_W-1:0]      win, rr_ptr, s1_tag, s2_tag;
  logic                  any, accept, s1_valid, s2_valid;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign ops[i] = {req_src1[MUL_W*i +: MUL_W], req_src2[MUL_W*i +: MUL_W],
                     req_src1_signed[i], req_src2_signed[i]};
  end

  rr_arbiter #(.N(NUM_REQ), .TAG_W(TAG_W)) u_arb (
    .req(req_valid), .ptr(rr_ptr), .gnt(gnt), .idx(win), .any(any)
  );

  // Stage 2 drains when empty or taken; stage 1 advances whenever stage 2 can.
  assign mul_a_en  = ~s2_valid | rsp_ready[s2_tag];
  assign mul_m_en  = ~s1_valid | mul_a_en;
  assign req_ready = gnt & {NUM_REQ{mul_m_en & ~reset}};
  assign accept    = any & mul_m_en & ~reset;

  assign sel             = any ? ops[win] : '0;
  assign mul_src1        = sel.src1;
  assign mul_src2        = sel.src2;
  assign mul_src1_signed = sel.src1_signed;
  assign mul_src2_signed = sel.src2_signed;
  assign mul_clr         = reset;

  assign rsp_valid  = s2_valid ? (NUM_REQ'(1) << s2_tag) : '0;
  assign rsp_result = mul_result;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_tag   <= '0;
      s2_tag   <= '0;
      rr_ptr   <= '0;
    end else begin
      if (mul_m_en) begin
        s1_valid <= accept;
        if (accept) begin
          s1_tag <= win;
          rr_ptr <= (win == TAG_W'(NUM_REQ - 1)) ? '0 : TAG_W'(win + 1'b1);
        end
      end
      if (mul_a_en) begin
        s2_valid <= s1_valid;
        s2_tag   <= s1_tag;
      end
    end
  end

`ifdef MULT_ARB_PERF_EN
  logic [31:0] ops_cnt, stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      ops_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept && ops_cnt != '1) ops_cnt <= ops_cnt + 32'd1;
      if (!mul_a_en && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_ops   = ops_cnt;
  assign perf_stall = stall_cnt;
`else
  assign perf_ops   = '0;
  assign perf_stall = '0;
`endif
endmodule

// File: tb/tb_mult_share_arb.sv
// Self-checking bench for mult_share_arb with a behavioural multiplier cell and in-order scoreboard.
module tb_mult_share_arb;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid, req_ready, req_src1_signed, req_src2_signed;
  logic [63:0] req_src1, req_src2;
  logic [1:0]  rsp_valid, rsp_ready;
  logic [63:0] rsp_result, mul_result;
  logic [31:0] mul_src1, mul_src2, perf_ops, perf_stall;
  logic        mul_src1_signed, mul_src2_signed, mul_m_en, mul_a_en, mul_clr;

`ifdef MULT_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  mult_share_arb #(.NUM_REQ(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src1(req_src1), .req_src2(req_src2),
    .req_src1_signed(req_src1_signed), .req_src2_signed(req_src2_signed),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .mul_src1(mul_src1), .mul_src2(mul_src2),
    .mul_src1_signed(mul_src1_signed), .mul_src2_signed(mul_src2_signed),
    .mul_m_en(mul_m_en), .mul_a_en(mul_a_en), .mul_clr(mul_clr),
    .mul_result(mul_result), .perf_ops(perf_ops), .perf_stall(perf_stall)
  );

  always #5 clk = ~clk;

  // Multiplier cell: operand register on m_en, product register on a_en, async clear.
  function automatic logic [63:0] cell_mul(logic [31:0] a, logic [31:0] b, logic sa, logic sb);
    longint x, y;
    x = $signed({sa & a[31], a});
    y = $signed({sb & b[31], b});
    return 64'(x * y);
  endfunction

  logic [31:0] ca, cb;
  logic        csa, csb;
  always @(posedge clk or posedge mul_clr) begin
    if (mul_clr) begin
      ca <= '0; cb <= '0; csa <= 1'b0; csb <= 1'b0; mul_result <= '0;
    end else begin
      if (mul_m_en) begin
        ca <= mul_src1; cb <= mul_src2; csa <= mul_src1_signed; csb <= mul_src2_signed;
      end
      if (mul_a_en) mul_result <= cell_mul(ca, cb, csa, csb);
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_proto
    a_hold: assert property (@(posedge clk) disable iff (reset)
      (req_valid[g] && !req_ready[g]) |=>
        (req_valid[g] && $stable(req_src1[32*g +: 32]) && $stable(req_src2[32*g +: 32])));
  end

  // Reference: zero- or sign-extend both operands to 64 bits and keep the low 64 bits.
  function automatic logic [63:0] ref_prod(logic [31:0] a, logic [31:0] b, logic sa, logic sb);
    logic [63:0] ea, eb;
    ea = sa ? {{32{a[31]}}, a} : {32'b0, a};
    eb = sb ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  typedef struct { int tag; logic [63:0] p; } exp_t;
  typedef struct {
    logic [31:0] a, b;
    logic        sa, sb;
    int          tag;
    logic [63:0] exp;
  } vec_t;

  exp_t q[$];
  vec_t tbl[8];
  int   n_cmp = 0, n_bad = 0, n_rsp = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mon();
    exp_t e;
    if (reset) begin
      q.delete();
      return;
    end
    if (rsp_valid != 0) check("rsp_onehot", 64'($onehot(rsp_valid)), 64'd1);
    if ((rsp_valid & rsp_ready) != 0) begin
      if (q.size() == 0) check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      else begin
        e = q.pop_front();
        check("rsp_tag", 64'(rsp_valid), 64'(1) << e.tag);
        check("rsp_data", rsp_result, e.p);
        n_rsp++;
      end
    end
    for (int i = 0; i < 2; i++)
      if (req_valid[i] && req_ready[i])
        q.push_back('{i, ref_prod(req_src1[32*i +: 32], req_src2[32*i +: 32],
                                  req_src1_signed[i], req_src2_signed[i])});
  endtask

  task automatic clk_step();
    #1;
    mon();
    @(negedge clk);
  endtask

  task automatic drive(int i, logic [31:0] a, logic [31:0] b, logic sa, logic sb);
    req_src1[32*i +: 32] = a;
    req_src2[32*i +: 32] = b;
    req_src1_signed[i]   = sa;
    req_src2_signed[i]   = sb;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    clk_step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int base, issued, launched;
    logic [1:0] pend, acc;

    tbl[0] = '{32'd3,         32'd5,         1'b0, 1'b0, 0, 64'd15};
    tbl[1] = '{32'hFFFF_FFFF, 32'd2,         1'b1, 1'b1, 1, 64'hFFFF_FFFF_FFFF_FFFE};
    tbl[2] = '{32'hFFFF_FFFF, 32'd2,         1'b0, 1'b0, 1, 64'h0000_0001_FFFF_FFFE};
    tbl[3] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 0, 64'h4000_0000_0000_0000};
    tbl[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 64'hFFFF_FFFF_0000_0001};
    tbl[5] = '{32'd0,         32'hDEAD_BEEF, 1'b1, 1'b1, 1, 64'd0};
    tbl[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1, 64'hFFFF_FFFE_0000_0001};
    tbl[7] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 0, 64'hC000_0000_8000_0000};

    req_valid = '0; req_src1 = '0; req_src2 = '0;
    req_src1_signed = '0; req_src2_signed = '0; rsp_ready = 2'b11;
    clk_step();
    clk_step();

    // Reset state
    req_valid = 2'b11;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_mul_clr", 64'(mul_clr), 64'd1);
    check("rst_perf_ops", 64'(perf_ops), 64'd0);
    check("rst_perf_stall", 64'(perf_stall), 64'd0);
    req_valid = '0;
    reset = 1'b0;
    clk_step();

    // Single ops: latency and product
    for (int v = 0; v < 8; v++) begin
      drive(tbl[v].tag, tbl[v].a, tbl[v].b, tbl[v].sa, tbl[v].sb);
      req_valid = 2'(1) << tbl[v].tag;
      #1;
      check("tbl_ready", 64'(req_ready), 64'(1) << tbl[v].tag);
      clk_step();
      req_valid = '0;
      check("tbl_lat1_idle", 64'(rsp_valid), 64'd0);
      clk_step();
      check("tbl_lat2_valid", 64'(rsp_valid), 64'(1) << tbl[v].tag);
      check("tbl_result", rsp_result, tbl[v].exp);
      clk_step();
    end

    // Fairness: both requesters always valid
    do_reset();
    drive(0, 32'd7, 32'd9, 1'b0, 1'b0);
    drive(1, 32'd11, 32'd13, 1'b1, 1'b0);
    req_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("fair_grant", 64'(req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
      clk_step();
    end
    check("fair_perf_ops", 64'(perf_ops), PERF ? 64'd8 : 64'd0);
    req_valid = 2'b01;
    clk_step();
    req_valid = '0;
    for (int k = 0; k < 3; k++) clk_step();

    // Back-pressure on requester 0 with full pipeline
    do_reset();
    rsp_ready = 2'b10;
    base = n_rsp;
    drive(0, 32'h0000_1234, 32'h0000_0010, 1'b0, 1'b0);
    req_valid = 2'b01;
    #1;
    check("bp_ready_a", 64'(req_ready), 64'd1);
    clk_step();
    drive(0, 32'hFFFF_0000, 32'd3, 1'b1, 1'b0);
    #1;
    check("bp_ready_b", 64'(req_ready), 64'd1);
    clk_step();
    drive(0, 32'd5, 32'd6, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_ready_held", 64'(req_ready), 64'd0);
      check("bp_valid_held", 64'(rsp_valid), 64'd1);
      check("bp_result_stable", rsp_result, 64'h0001_2340);
      clk_step();
    end
    check("bp_perf_stall", 64'(perf_stall), PERF ? 64'd3 : 64'd0);
    rsp_ready = 2'b11;
    #1;
    check("bp_ready_c", 64'(req_ready), 64'd1);
    clk_step();
    req_valid = '0;
    for (int k = 0; k < 4; k++) clk_step();
    check("bp_rsp_count", 64'(n_rsp - base), 64'd3);

    // Reset with two ops in flight
    do_reset();
    drive(0, 32'd100, 32'd200, 1'b0, 1'b0);
    req_valid = 2'b01;
    clk_step();
    drive(1, 32'd300, 32'd400, 1'b0, 1'b0);
    req_valid = 2'b10;
    clk_step();
    req_valid = '0;
    reset = 1'b1;
    clk_step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("mid_rst_no_rsp", 64'(rsp_valid), 64'd0);
      clk_step();
    end
    drive(0, 32'd6, 32'd7, 1'b0, 1'b0);
    drive(1, 32'd8, 32'd9, 1'b0, 1'b0);
    req_valid = 2'b11;
    #1;
    check("mid_rst_ptr", 64'(req_ready), 64'd1);
    clk_step();
    req_valid = 2'b10;
    check("mid_lat1_idle", 64'(rsp_valid), 64'd0);
    clk_step();
    req_valid = '0;
    check("mid_valid0", 64'(rsp_valid), 64'd1);
    check("mid_result0", rsp_result, 64'd42);
    clk_step();
    check("mid_valid1", 64'(rsp_valid), 64'd2);
    check("mid_result1", rsp_result, 64'd72);
    clk_step();

    // Random streaming with random response back-pressure
    do_reset();
    base = n_rsp; issued = 0; launched = 0; pend = '0;
    for (int cyc = 0; cyc < 3000 && (issued < 100 || n_rsp - base < 100); cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && launched < 100 && $urandom_range(0, 3) != 0) begin
          drive(i, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom),
                ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : 32'($urandom),
                1'($urandom), 1'($urandom));
          pend[i] = 1'b1;
          launched++;
        end
      end
      req_valid = pend;
      rsp_ready = 2'($urandom_range(0, 3));
      #1;
      acc = req_valid & req_ready;
      clk_step();
      for (int i = 0; i < 2; i++)
        if (acc[i]) begin
          pend[i] = 1'b0;
          issued++;
        end
    end
    req_valid = '0;
    rsp_ready = 2'b11;
    clk_step();
    check("rand_issued", 64'(issued), 64'd100);
    check("rand_rsp_count", 64'(n_rsp - base), 64'd100);
    check("rand_queue_empty", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mult_share_arb.md
# mult_share_arb

Round-robin arbiter and pipeline sequencer that shares one 32x32 two-stage pipelined multiplier cell (registered inputs on stage-1 enable, registered result on stage-2 enable, 64-bit result) between NUM_REQ requesters. Accepts operand requests over valid/ready, drives the cell's operands, sign controls and both stage enables, and routes each 64-bit product back to the issuing requester over a back-pressurable response channel. Sits between the custom-instruction/UDP checksum clients and the multiplier cell.

## Interface
- NUM_REQ, 2: number of requesters (2..8)
- TAG_W, $clog2(NUM_REQ) (min 1): requester index width
---
- clk  in  1  single clock; also drives both multiplier clocks
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept
- req_src1  in  NUM_REQ*32  operand A, requester i at [32i+31:32i]
- req_src2  in  NUM_REQ*32  operand B
- req_src1_signed  in  NUM_REQ  A is signed
- req_src2_signed  in  NUM_REQ  B is signed
- rsp_valid  out  NUM_REQ  one-hot; product available for requester i
- rsp_ready  in  NUM_REQ  requester i takes product
- rsp_result  out  64  shared product bus, valid for whichever rsp_valid bit is set
- mul_src1, mul_src2  out  32  to multiplier dataa/datab
- mul_src1_signed, mul_src2_signed  out  1  to multiplier signa/signb
- mul_m_en  out  1  stage-1 (input register) enable
- mul_a_en  out  1  stage-2 (output register) enable
- mul_clr  out  1  multiplier aclr, equals reset
- mul_result  in  64  multiplier result
- perf_ops  out  32  accepted operations (see Configuration)
- perf_stall  out  32  cycles with stage 2 held

## Operation
- Pipeline tracking: s1_valid/s1_tag mirror the cell's input register; s2_valid/s2_tag mirror its output register.
- mul_a_en = ~s2_valid | rsp_ready[s2_tag]; mul_m_en = ~s1_valid | mul_a_en.
- Arbitration: rotating priority starting at pointer rr_ptr; winner = first i at or after rr_ptr (mod NUM_REQ) with req_valid[i]. req_ready[winner] = mul_m_en; all others 0. Combinational from req_valid, rr_ptr and state.
- Mux: mul_src*/mul_src*_signed = winner's fields; when no request, drive zeros.
- On accept (req_valid[w] & req_ready[w]): s1_valid <= 1, s1_tag <= w, rr_ptr <= (w+1) mod NUM_REQ.
- On mul_m_en without accept: s1_valid <= 0.
- On mul_a_en: s2_valid <= s1_valid, s2_tag <= s1_tag.
- rsp_valid = s2_valid ? onehot(s2_tag) : 0; rsp_result = mul_result.
- While held (s2_valid & ~rsp_ready[s2_tag]): both enables 0, rsp_result stable, no accepts, rr_ptr unchanged.
- Requesters keep req_valid and operands stable until accepted; changing them earlier is a protocol violation (bench asserts).
- Signedness is passed through; the product arithmetic is the cell's (signed/unsigned per flag, full 64-bit result).

## Timing
- Reset values: s1_valid=0, s2_valid=0, tags 0, rr_ptr=0, req_ready=0 while reset high, rsp_valid=0, perf counters 0, mul_clr=1.
- Latency: accept at edge T -> rsp_valid at T+2 with no back-pressure; throughput 1 op/clk.
- Simultaneous drain and accept in same cycle is allowed (full pipeline keeps streaming).
- Reset mid-operation: in-flight ops discarded, no response issued for them; first accept possible the cycle after reset drops.
- A requester may have multiple ops in flight; responses return in order.

## Configuration
- MULT_ARB_PERF_EN defined: perf_ops increments on each accept, perf_stall increments each cycle stage 2 is held; both saturate at 32'hFFFFFFFF, clear on reset.
- Undefined: counter logic absent, perf_ops and perf_stall tied to 0.

## Structure
- Package mult_arb_pkg: MUL_W=32, RES_W=64, MAX_REQ=8, tag width function.
- Sub-module rr_arbiter (request vector + pointer -> one-hot grant + winner index); pipeline tracking and mux stay in mult_share_arb. The multiplier cell is instantiated by the parent, not inside this block.

## Test plan
- Single op: req 0, 0x0000_0003 x 0x0000_0005 unsigned -> rsp_valid[0] at T+2, rsp_result 15.
- Signed: req 1, 0xFFFF_FFFF x 0x0000_0002 both signed -> 0xFFFF_FFFF_FFFF_FFFE; same operands unsigned -> 0x0000_0001_FFFF_FFFE.
- Fairness: both requesters always valid for 8 accepts -> grants alternate 0,1,0,1...; perf_ops=8 with MULT_ARB_PERF_EN.
- Back-pressure: rsp_ready[0]=0 for 3 cycles with pipeline full -> rsp_result stable, req_ready all 0, perf_stall=3, no op lost or duplicated, order preserved.
- Reset mid-flight: two ops accepted, reset pulsed next cycle -> no rsp_valid afterwards, rr_ptr=0, next op returns correct product in 2 cycles.
- Back-to-back streaming 100 random ops, random rsp_ready -> every product matches reference model, in order, per tag.
